// File: rtl/model_scheduler.sv
// Frame-level model scheduler: issues one transform-pipeline job per model,
// counts emitted triangles and aborts the frame if the pipeline stops making progress.
`timescale 1ns/1ps
module model_scheduler #(
  parameter int MAX_MODEL_COUNT = 16,
  parameter int TRI_COUNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES  = 65536,
  localparam int CW = $clog2(MAX_MODEL_COUNT + 1),
  localparam int IW = (MAX_MODEL_COUNT > 1) ? $clog2(MAX_MODEL_COUNT) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_frame_start,
  input  logic [CW-1:0]              i_model_count,
  output logic                       o_busy,
  output logic                       o_frame_done,
  output logic                       o_error,
  output logic [IW-1:0]              o_model_id,
  output logic                       o_tp_start,
  input  logic                       i_tp_ready,
  input  logic                       i_tp_done,
  output logic                       o_tp_next,
  input  logic                       i_raster_ready,
  input  logic                       i_triangle_dv,
  output logic [TRI_COUNT_WIDTH-1:0] o_triangle_count
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_t;

  state_t                     state_reg, state_next;
  logic [CW-1:0]              count_reg, count_next;
  logic [IW-1:0]              model_id_reg, model_id_next;
  logic [TRI_COUNT_WIDTH-1:0] tri_reg, tri_next;
  logic [WW-1:0]              wd_reg, wd_next;
  logic                       error_reg, error_next;
  logic                       tp_start_reg, tp_start_next;
  logic                       frame_done_reg, frame_done_next;
  logic [CW-1:0]              clamped_count;
  logic                       last_model;

  assign clamped_count = (i_model_count > CW'(MAX_MODEL_COUNT)) ? CW'(MAX_MODEL_COUNT) : i_model_count;
  assign last_model    = (CW'(model_id_reg) + CW'(1)) == count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      model_id_reg   <= '0;
      tri_reg        <= '0;
      wd_reg         <= '0;
      error_reg      <= 1'b0;
      tp_start_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      model_id_reg   <= model_id_next;
      tri_reg        <= tri_next;
      wd_reg         <= wd_next;
      error_reg      <= error_next;
      tp_start_reg   <= tp_start_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    model_id_next   = model_id_reg;
    tri_next        = tri_reg;
    wd_next         = wd_reg;
    error_next      = error_reg;
    tp_start_next   = 1'b0;
    frame_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_frame_start) begin
          count_next    = clamped_count;
          model_id_next = '0;
          tri_next      = '0;
          error_next    = 1'b0;
          wd_next       = '0;
          state_next    = (clamped_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (i_tp_ready) begin
          tp_start_next = 1'b1;
          wd_next       = '0;
          state_next    = RUN;
        end
      end
      RUN: begin
        if (i_triangle_dv && (tri_reg != '1))
          tri_next = tri_reg + TRI_COUNT_WIDTH'(1);
        // done wins over a simultaneous triangle and over an expiring watchdog
        if (i_tp_done) begin
          wd_next = '0;
          if (last_model) begin
            state_next = DONE;
          end else begin
            model_id_next = model_id_reg + IW'(1);
            state_next    = ISSUE;
          end
        end else if (i_triangle_dv) begin
          wd_next = '0;
        end else if (i_raster_ready) begin
          // a stalled rasterizer freezes the watchdog
          if (wd_reg == WW'(TIMEOUT_CYCLES - 1)) begin
            error_next = 1'b1;
            state_next = DONE;
          end else begin
            wd_next = wd_reg + WW'(1);
          end
        end
      end
      DONE: begin
        frame_done_next = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_busy           = (state_reg != IDLE);
  assign o_frame_done     = frame_done_reg;
  assign o_error          = error_reg;
  assign o_model_id       = model_id_reg;
  assign o_tp_start       = tp_start_reg;
  assign o_tp_next        = (state_reg == RUN) && i_raster_ready;
  assign o_triangle_count = tri_reg;

endmodule

// File: tb/tb_model_scheduler.sv
// Scenario bench for model_scheduler; expected model ids are queued at frame start
// and popped by a monitor whenever o_tp_start fires.
`timescale 1ns/1ps
module tb_model_scheduler;

  localparam int MAX = 16;
  localparam int TW  = 4;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_frame_start = 1'b0;
  logic [4:0]    i_model_count = '0;
  logic          o_busy, o_frame_done, o_error, o_tp_start, o_tp_next;
  logic [3:0]    o_model_id;
  logic          i_tp_ready = 1'b1;
  logic          i_tp_done = 1'b0;
  logic          i_raster_ready = 1'b1;
  logic          i_triangle_dv = 1'b0;
  logic [TW-1:0] o_triangle_count;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int exp_q[$];

  model_scheduler #(.MAX_MODEL_COUNT(MAX), .TRI_COUNT_WIDTH(TW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .i_frame_start(i_frame_start), .i_model_count(i_model_count),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_error(o_error), .o_model_id(o_model_id),
    .o_tp_start(o_tp_start), .i_tp_ready(i_tp_ready), .i_tp_done(i_tp_done), .o_tp_next(o_tp_next),
    .i_raster_ready(i_raster_ready), .i_triangle_dv(i_triangle_dv), .o_triangle_count(o_triangle_count)
  );

  always #5 clk = ~clk;

  // scoreboard: each start pulse must carry the next queued model id
  always @(negedge clk) begin
    if (o_frame_done) done_cnt++;
    if (o_tp_start) begin
      int e;
      start_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL start_unexpected: got model_id %0d, expected no start", o_model_id);
      end else begin
        e = exp_q.pop_front();
        if (o_model_id !== 4'(e)) begin
          n_err++;
          $display("FAIL start_model_id: got %0d expected %0d", o_model_id, e);
        end else begin
          $display("start model_id=%0d ok", o_model_id);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int cnt);
    int n;
    n = (cnt > MAX) ? MAX : cnt;
    for (int i = 0; i < n; i++) exp_q.push_back(i);
    i_model_count = 5'(cnt);
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    $display("frame start count=%0d", cnt);
  endtask

  task automatic wait_start();
    int k = 0;
    while (!o_tp_start && k < 50) begin tick(); k++; end
    if (!o_tp_start) begin
      n_cmp++; n_err++;
      $display("FAIL wait_start_timeout: got no o_tp_start, expected one within 50 cycles");
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!o_frame_done && k < 200) begin tick(); k++; end
    n_cmp++;
    if (!o_frame_done) begin
      n_err++;
      $display("FAIL wait_done_timeout: got o_frame_done=0, expected 1 within 200 cycles");
    end
  endtask

  // one pipeline job: dv on every 4th cycle (ndv of them), done presented in cycle 'delay'
  task automatic run_model(input int ndv, input int delay, input bit poke);
    wait_start();
    for (int c = 1; c < delay; c++) begin
      i_triangle_dv = (c % 4 == 0) && (c / 4 <= ndv);
      i_frame_start = poke && (c == 2);
      i_model_count = poke ? 5'd2 : i_model_count;
      tick();
    end
    i_triangle_dv = 1'b0;
    i_frame_start = 1'b0;
    i_tp_done = 1'b1;
    tick();
    i_tp_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({o_busy, o_frame_done, o_error, o_model_id, o_tp_start, o_tp_next, o_triangle_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {o_busy, o_frame_done, o_error, o_model_id, o_tp_start, o_tp_next, o_triangle_count});
    end
    rst = 1'b0;
    tick();
    $display("reset checked");
  endtask

  task automatic test_three_models();
    int s0, d0;
    s0 = start_cnt; d0 = done_cnt;
    start_frame(3);
    for (int m = 0; m < 3; m++) run_model(4, 20, 1'b0);
    wait_done();
    n_cmp++;
    if (o_triangle_count !== TW'(12)) begin n_err++; $display("FAIL three_tri_count: got %0d expected 12", o_triangle_count); end
    n_cmp++;
    if (o_error !== 1'b0) begin n_err++; $display("FAIL three_error: got %0d expected 0", o_error); end
    tick(); tick();
    n_cmp++;
    if (start_cnt - s0 != 3) begin n_err++; $display("FAIL three_starts: got %0d expected 3", start_cnt - s0); end
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_err++; $display("FAIL three_done_pulses: got %0d expected 1", done_cnt - d0); end
    $display("three-model frame: tri=%0d error=%0d", o_triangle_count, o_error);
  endtask

  task automatic test_empty_frame();
    int s0;
    s0 = start_cnt;
    start_frame(0);
    n_cmp++;
    if (o_busy !== 1'b1 || o_frame_done !== 1'b0) begin
      n_err++; $display("FAIL empty_cycle1: got busy=%0d done=%0d expected busy=1 done=0", o_busy, o_frame_done);
    end
    tick();
    n_cmp++;
    if (o_busy !== 1'b0 || o_frame_done !== 1'b1) begin
      n_err++; $display("FAIL empty_cycle2: got busy=%0d done=%0d expected busy=0 done=1", o_busy, o_frame_done);
    end
    tick();
    n_cmp++;
    if (o_frame_done !== 1'b0) begin n_err++; $display("FAIL empty_done_width: got %0d expected 0", o_frame_done); end
    n_cmp++;
    if (start_cnt != s0) begin n_err++; $display("FAIL empty_starts: got %0d expected 0", start_cnt - s0); end
    $display("empty frame checked");
  endtask

  task automatic test_backpressure();
    bit bad = 1'b0;
    start_frame(1);
    wait_start();
    i_raster_ready = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      #1;
      if (o_tp_next !== 1'b0 || o_error !== 1'b0 || o_busy !== 1'b1) bad = 1'b1;
      tick();
    end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL stall_hold: got tp_next/error activity during stall, expected none"); end
    i_raster_ready = 1'b1;
    #1;
    n_cmp++;
    if (o_tp_next !== 1'b1) begin n_err++; $display("FAIL tp_next_follow: got %0d expected 1", o_tp_next); end
    i_triangle_dv = 1'b1;
    tick(); tick();
    i_triangle_dv = 1'b0;
    i_tp_done = 1'b1;
    tick();
    i_tp_done = 1'b0;
    wait_done();
    n_cmp++;
    if (o_error !== 1'b0 || o_triangle_count !== TW'(2)) begin
      n_err++; $display("FAIL stall_complete: got error=%0d tri=%0d expected 0 and 2", o_error, o_triangle_count);
    end
    tick();
    $display("backpressure frame: tri=%0d error=%0d", o_triangle_count, o_error);
  endtask

  task automatic test_watchdog();
    int s0;
    s0 = start_cnt;
    start_frame(3);
    run_model(1, 5, 1'b0);
    wait_start();
    for (int k = 0; k < TO - 1; k++) tick();
    n_cmp++;
    if (o_error !== 1'b0) begin n_err++; $display("FAIL wd_early: got error=%0d expected 0", o_error); end
    tick();
    n_cmp++;
    if (o_error !== 1'b1) begin n_err++; $display("FAIL wd_error: got %0d expected 1", o_error); end
    tick();
    n_cmp++;
    if (o_frame_done !== 1'b1 || o_model_id !== 4'd1) begin
      n_err++; $display("FAIL wd_done: got done=%0d model_id=%0d expected 1 and 1", o_frame_done, o_model_id);
    end
    tick(); tick();
    n_cmp++;
    if (start_cnt - s0 != 2 || o_error !== 1'b1) begin
      n_err++; $display("FAIL wd_skip: got starts=%0d error=%0d expected 2 and 1", start_cnt - s0, o_error);
    end
    exp_q.delete();
    $display("watchdog abort at model %0d", o_model_id);
  endtask

  task automatic test_overrun_clamp();
    int s0;
    s0 = start_cnt;
    start_frame(MAX + 15);
    run_model(1, 5, 1'b1);
    for (int m = 1; m < MAX; m++) run_model(1, 5, 1'b0);
    wait_done();
    tick(); tick();
    n_cmp++;
    if (start_cnt - s0 != MAX) begin n_err++; $display("FAIL clamp_starts: got %0d expected %0d", start_cnt - s0, MAX); end
    n_cmp++;
    if (o_triangle_count !== TW'(15)) begin n_err++; $display("FAIL tri_saturate: got %0d expected 15", o_triangle_count); end
    n_cmp++;
    if (o_busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL overrun_ignored: got busy=%0d pending=%0d expected 0 and 0", o_busy, exp_q.size());
    end
    $display("clamped frame: starts=%0d tri=%0d", start_cnt - s0, o_triangle_count);
  endtask

  task automatic test_mid_reset();
    int d0, s0;
    start_frame(3);
    run_model(2, 12, 1'b0);
    wait_start();
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_busy, o_frame_done, o_error, o_model_id, o_tp_start, o_tp_next, o_triangle_count} !== '0) begin
      n_err++; $display("FAIL mid_reset_outputs: got %b expected all zero",
                        {o_busy, o_frame_done, o_error, o_model_id, o_tp_start, o_tp_next, o_triangle_count});
    end
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 5; k++) tick();
    n_cmp++;
    if (done_cnt != d0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_abort: got done pulses=%0d busy=%0d expected 0 and 0", done_cnt - d0, o_busy);
    end
    s0 = start_cnt;
    start_frame(2);
    run_model(1, 6, 1'b0);
    run_model(1, 6, 1'b0);
    wait_done();
    n_cmp++;
    if (o_triangle_count !== TW'(2) || start_cnt - s0 != 2) begin
      n_err++; $display("FAIL post_reset_frame: got tri=%0d starts=%0d expected 2 and 2", o_triangle_count, start_cnt - s0);
    end
    tick();
    $display("mid-frame reset recovered: tri=%0d", o_triangle_count);
  endtask

  initial begin
    test_reset();
    test_three_models();
    test_empty_frame();
    test_backpressure();
    test_watchdog();
    test_overrun_clamp();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/model_scheduler.md
MODEL_SCHEDULER -- requirements
Module: model_scheduler

Interface
REQ-001 SHALL have parameter MAX_MODEL_COUNT, default 16: maximum models per frame.
REQ-002 SHALL have parameter TRI_COUNT_WIDTH, default 16: triangle counter width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536: watchdog limit, in cycles without progress.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port i_frame_start, input, 1: frame request pulse.
REQ-007 SHALL have port i_model_count, input, $clog2(MAX_MODEL_COUNT+1): models in the frame; sampled with i_frame_start.
REQ-008 SHALL have port o_busy, output, 1: frame in progress.
REQ-009 SHALL have port o_frame_done, output, 1: one-cycle end-of-frame pulse.
REQ-010 SHALL have port o_error, output, 1: sticky watchdog abort flag.
REQ-011 SHALL have port o_model_id, output, $clog2(MAX_MODEL_COUNT): index of the model being transformed.
REQ-012 SHALL have port o_tp_start, output, 1: transform pipeline start pulse.
REQ-013 SHALL have port i_tp_ready, input, 1: transform pipeline idle/ready.
REQ-014 SHALL have port i_tp_done, input, 1: transform pipeline done pulse.
REQ-015 SHALL have port o_tp_next, output, 1: transform pipeline next-triangle enable.
REQ-016 SHALL have port i_raster_ready, input, 1: downstream rasterizer can accept a triangle.
REQ-017 SHALL have port i_triangle_dv, input, 1: triangle emitted by the pipeline.
REQ-018 SHALL have port o_triangle_count, output, TRI_COUNT_WIDTH: triangles emitted this frame.

Function
REQ-019 SHALL implement the states IDLE, ISSUE, RUN, DONE.
REQ-020 SHALL, in IDLE, drive o_busy=0; all other states SHALL drive o_busy=1.
REQ-021 SHALL, in IDLE on i_frame_start, latch min(i_model_count, MAX_MODEL_COUNT), clear o_model_id, o_triangle_count, o_error and the watchdog.
REQ-022 SHALL, on that IDLE transition, go to DONE when the latched count is 0, otherwise to ISSUE.
REQ-023 SHALL ignore i_frame_start outside IDLE, with no state change and no queued request.
REQ-024 SHALL, in ISSUE, wait for i_tp_ready=1.
REQ-025 SHALL, when i_tp_ready=1 in ISSUE, register o_tp_start=1 for exactly one cycle and move to RUN in the same edge.
REQ-026 SHALL drive o_tp_start=0 at all other times.
REQ-027 SHALL drive o_tp_next = i_raster_ready combinationally while in RUN, and 0 in every other state.
REQ-028 SHALL increment o_triangle_count by 1 on each cycle with i_triangle_dv=1 in RUN.
REQ-029 SHALL saturate o_triangle_count at all-ones; no wrap.
REQ-030 SHALL, on i_tp_done in RUN with o_model_id == latched count-1, move to DONE.
REQ-031 SHALL, on i_tp_done in RUN otherwise, increment o_model_id and return to ISSUE.
REQ-032 SHALL treat i_tp_done as taking priority when i_tp_done and i_triangle_dv are both high in one cycle; that triangle is still counted.
REQ-033 SHALL run a watchdog counter in RUN only; it clears on i_triangle_dv or i_tp_done and clears on entry to RUN.
REQ-034 SHALL hold the watchdog while i_raster_ready=0, since a stall is not a fault.
REQ-035 SHALL, when the watchdog reaches TIMEOUT_CYCLES-1, set o_error=1 and move to DONE, skipping the remaining models.
REQ-036 SHALL, in DONE, assert o_frame_done for exactly one cycle, then move to IDLE.
REQ-037 SHALL hold o_triangle_count, o_model_id and o_error stable from DONE until the next accepted i_frame_start.
REQ-038 SHALL ignore i_tp_done and i_triangle_dv outside RUN.

Reset
REQ-039 SHALL, while rst=1, asynchronously force state IDLE and all outputs 0 (o_busy, o_frame_done, o_error, o_model_id, o_tp_start, o_tp_next, o_triangle_count), and clear the latched count and the watchdog.
REQ-040 SHALL treat rst asserted mid-frame as an abort: no o_frame_done pulse is produced, and the block is IDLE on the first edge after rst deasserts.

Verification
REQ-041 SHALL be verified for a 3-model frame: i_model_count=3, tp_ready=1, tp_done 20 cycles after each start, 4 triangle_dv per model -> 3 o_tp_start pulses with o_model_id 0,1,2, o_triangle_count=12, one o_frame_done, o_error=0.
REQ-042 SHALL be verified for an empty frame: i_model_count=0 -> no o_tp_start, o_frame_done exactly 2 cycles after i_frame_start, o_busy high for 1 cycle.
REQ-043 SHALL be verified for backpressure: i_raster_ready=0 for 100000 cycles in RUN with TIMEOUT_CYCLES=65536 -> o_tp_next=0 throughout, no error; after ready returns and tp_done arrives -> normal completion.
REQ-044 SHALL be verified for the watchdog: TIMEOUT_CYCLES=16, raster ready, no dv/done -> o_error=1 after 16 RUN cycles, o_frame_done pulses, and o_model_id holds the stuck index.
REQ-045 SHALL be verified for overrun and clamping: i_frame_start during RUN -> ignored; i_model_count=MAX_MODEL_COUNT+... clamped, so exactly MAX_MODEL_COUNT starts occur.
REQ-046 SHALL be verified for mid-frame reset: rst pulsed in RUN after model 1 -> all outputs 0 immediately, no o_frame_done, and a new frame afterwards completes normally.
